// File: rtl/alu_datapath_pkg.sv
// Shared constants for the alu_datapath block: ALU opcodes, operand-pair
// selects, R2 source selects and load-enable bit positions.
package alu_datapath_pkg;

    // ALU opcodes (S input)
    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_NOT  = 3'b111;

    // Operand-pair selects (SEL input)
    localparam logic [1:0] SEL_R0R1 = 2'b00;
    localparam logic [1:0] SEL_R3R1 = 2'b01;
    localparam logic [1:0] SEL_R3R0 = 2'b10;
    localparam logic [1:0] SEL_R3R3 = 2'b11;

    // R2 source selects (W input); unlisted codes load zero
    localparam logic [2:0] W_R0  = 3'b000;
    localparam logic [2:0] W_R1  = 3'b001;
    localparam logic [2:0] W_ALU = 3'b010;
    localparam logic [2:0] W_R3  = 3'b100;

    // Bit positions inside the CE load-enable word
    localparam int CE_R0 = 0;
    localparam int CE_R1 = 1;
    localparam int CE_R2 = 2;
    localparam int CE_R3 = 3;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result and carry/borrow for one operand pair.
// Build option: define ALU_SAT_EN to make add/subtract saturate instead of
// wrapping; the carry output always reports the raw carry/borrow.
module alu_core
    import alu_datapath_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic [2:0]       i_op,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    // One extra bit so the top bit is the carry out, or the borrow for subtract
    assign w_sum  = {1'b0, i_x} + {1'b0, i_y};
    assign w_diff = {1'b0, i_x} - {1'b0, i_y};

    // Opcode decode; logic ops and pass/invert never produce a carry
    always_comb begin
        o_result = '0;
        o_carry  = 1'b0;
        case (i_op)
            OP_PASS: o_result = i_x;
            OP_ADD: begin
                o_carry = w_sum[WIDTH];
`ifdef ALU_SAT_EN
                o_result = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
`else
                o_result = w_sum[WIDTH-1:0];
`endif
            end
            OP_SUB: begin
                o_carry = w_diff[WIDTH];
`ifdef ALU_SAT_EN
                o_result = w_diff[WIDTH] ? '0 : w_diff[WIDTH-1:0];
`else
                o_result = w_diff[WIDTH-1:0];
`endif
            end
            OP_AND:  o_result = i_x & i_y;
            OP_OR:   o_result = i_x | i_y;
            OP_XOR:  o_result = i_x ^ i_y;
            OP_SHL: begin
                o_result = {i_x[WIDTH-2:0], 1'b0};
                o_carry  = i_x[WIDTH-1];
            end
            OP_NOT:  o_result = ~i_x;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_datapath.sv
// Datapath stage behind the sequencing FSM: four registers R0..R3, operand
// muxing into alu_core, R2 as the visible output and ZERO/CARRY/VALID/DONE.
// Build option: ALU_SAT_EN (saturating add/subtract, handled in alu_core).
module alu_datapath
    import alu_datapath_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CLR,
    input  logic [2:0]       W,
    input  logic [3:0]       CE,
    input  logic [1:0]       SEL,
    input  logic [2:0]       S,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y,
    output logic             ZERO,
    output logic             CARRY,
    output logic             VALID,
    output logic             DONE
);

    logic [WIDTH-1:0] r_r0;
    logic [WIDTH-1:0] r_r1;
    logic [WIDTH-1:0] r_r2;
    logic [WIDTH-1:0] r_r3;
    logic             r_zero;
    logic             r_carry;
    logic             r_valid;
    logic             r_done;

    logic [WIDTH-1:0] w_opx;
    logic [WIDTH-1:0] w_opy;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_carry;
    logic [WIDTH-1:0] w_r2_src;

    // Operand pair for the ALU, chosen by SEL
    always_comb begin
        w_opx = r_r3;
        w_opy = r_r1;
        case (SEL)
            SEL_R0R1: begin w_opx = r_r0; w_opy = r_r1; end
            SEL_R3R1: begin w_opx = r_r3; w_opy = r_r1; end
            SEL_R3R0: begin w_opx = r_r3; w_opy = r_r0; end
            SEL_R3R3: begin w_opx = r_r3; w_opy = r_r3; end
            default:  begin w_opx = r_r3; w_opy = r_r1; end
        endcase
    end

    alu_core #(
        .WIDTH(WIDTH)
    ) u_alu_core (
        .i_x      (w_opx),
        .i_y      (w_opy),
        .i_op     (S),
        .o_result (w_alu_result),
        .o_carry  (w_alu_carry)
    );

    // R2 source mux; R3 here is the pre-edge value even when R3 loads too
    always_comb begin
        w_r2_src = '0;
        case (W)
            W_R0:    w_r2_src = r_r0;
            W_R1:    w_r2_src = r_r1;
            W_ALU:   w_r2_src = w_alu_result;
            W_R3:    w_r2_src = r_r3;
            default: w_r2_src = '0;
        endcase
    end

    // Register file and flags: CLR beats loads, DONE pulses on the first R2 load
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_r0    <= '0;
            r_r1    <= '0;
            r_r2    <= '0;
            r_r3    <= '0;
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else if (CLR) begin
            r_r0    <= '0;
            r_r1    <= '0;
            r_r2    <= '0;
            r_r3    <= '0;
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            if (CE[CE_R0]) r_r0 <= A;
            if (CE[CE_R1]) r_r1 <= B;
            if (CE[CE_R2]) begin
                r_r2    <= w_r2_src;
                r_valid <= 1'b1;
            end
            if (CE[CE_R3]) begin
                r_r3    <= w_alu_result;
                r_zero  <= (w_alu_result == '0);
                r_carry <= w_alu_carry;
            end
            r_done <= CE[CE_R2] && !r_valid;
        end
    end

    assign Y     = r_r2;
    assign ZERO  = r_zero;
    assign CARRY = r_carry;
    assign VALID = r_valid;
    assign DONE  = r_done;

endmodule

// File: tb/tb_alu_datapath.sv
// Directed bench for alu_datapath with a queue of expected output snapshots.
// Expected values follow the ALU_SAT_EN build option when it is defined.
module tb_alu_datapath;

    logic       CLK;
    logic       RESET;
    logic       CLR;
    logic [2:0] W;
    logic [3:0] CE;
    logic [1:0] SEL;
    logic [2:0] S;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] Y;
    logic       ZERO;
    logic       CARRY;
    logic       VALID;
    logic       DONE;

    typedef struct {
        string      tag;
        logic [7:0] y;
        logic       zero;
        logic       carry;
        logic       valid;
        logic       done;
    } expect_t;

    expect_t sbQueue[$];
    int      errorCount = 0;
    int      checkCount = 0;

`ifdef ALU_SAT_EN
    localparam logic [7:0] ADD_WRAP_RES = 8'd255;
    localparam logic [7:0] SUB_BORROW_RES = 8'd0;
    localparam logic       SUB_BORROW_ZERO = 1'b1;
`else
    localparam logic [7:0] ADD_WRAP_RES = 8'd44;
    localparam logic [7:0] SUB_BORROW_RES = 8'd254;
    localparam logic       SUB_BORROW_ZERO = 1'b0;
`endif

    alu_datapath #(
        .WIDTH(8)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .CLR   (CLR),
        .W     (W),
        .CE    (CE),
        .SEL   (SEL),
        .S     (S),
        .A     (A),
        .B     (B),
        .Y     (Y),
        .ZERO  (ZERO),
        .CARRY (CARRY),
        .VALID (VALID),
        .DONE  (DONE)
    );

    // Free-running 10-time-unit clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Guard against a hung run
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected end of stimulus");
        $fatal(1, "[TB] watchdog expired");
    end

    // Queue the output snapshot the DUT should show after the next step
    task automatic expectOut(input string tag, input logic [7:0] y, input logic z,
                             input logic c, input logic v, input logic d);
        expect_t e;
        e.tag = tag;
        e.y = y;
        e.zero = z;
        e.carry = c;
        e.valid = v;
        e.done = d;
        sbQueue.push_back(e);
    endtask

    // Drive one control word at the falling edge, then settle past the rising edge
    task automatic applyStimulus(input logic clr, input logic [3:0] ce, input logic [1:0] sel,
                                 input logic [2:0] s, input logic [2:0] w,
                                 input logic [7:0] a, input logic [7:0] b);
        @(negedge CLK);
        CLR = clr;
        CE = ce;
        SEL = sel;
        S = s;
        W = w;
        A = a;
        B = b;
        @(posedge CLK);
        #1;
    endtask

    // Pop the oldest expectation and compare it with the live outputs
    task automatic checkOutput();
        expect_t e;
        logic [11:0] observed;
        logic [11:0] expected;
        checkCount++;
        if (sbQueue.size() == 0) begin
            errorCount++;
            $error("[TB] FAIL scoreboard_empty: observed no entry, expected one");
        end else begin
            e = sbQueue.pop_front();
            observed = {Y, ZERO, CARRY, VALID, DONE};
            expected = {e.y, e.zero, e.carry, e.valid, e.done};
            assert (observed === expected)
            else begin
                errorCount++;
                $error("[TB] FAIL %s: observed Y=%0d Z=%b C=%b V=%b D=%b, expected Y=%0d Z=%b C=%b V=%b D=%b",
                       e.tag, Y, ZERO, CARRY, VALID, DONE, e.y, e.zero, e.carry, e.valid, e.done);
            end
        end
    endtask

    // One full step: queue expectation, drive, compare
    task automatic step(input string tag, input logic clr, input logic [3:0] ce,
                        input logic [1:0] sel, input logic [2:0] s, input logic [2:0] w,
                        input logic [7:0] a, input logic [7:0] b, input logic [7:0] y,
                        input logic z, input logic c, input logic v, input logic d);
        expectOut(tag, y, z, c, v, d);
        applyStimulus(clr, ce, sel, s, w, a, b);
        checkOutput();
    endtask

    // Default control program A=5, B=3 up to the first R2 load (Y=5, DONE pulse)
    task automatic runDefault(input string pfx);
        step({pfx, "_clr"},     1'b1, 4'b0000, 2'b00, 3'b000, 3'b000, 8'd0, 8'd0, 8'd0, 0, 0, 0, 0);
        step({pfx, "_load_ab"}, 1'b0, 4'b0011, 2'b00, 3'b000, 3'b000, 8'd5, 8'd3, 8'd0, 0, 0, 0, 0);
        step({pfx, "_sub"},     1'b0, 4'b1000, 2'b00, 3'b010, 3'b000, 8'd5, 8'd3, 8'd0, 0, 0, 0, 0);
        step({pfx, "_add"},     1'b0, 4'b1000, 2'b01, 3'b001, 3'b000, 8'd5, 8'd3, 8'd0, 0, 0, 0, 0);
        step({pfx, "_y_first"}, 1'b0, 4'b0100, 2'b01, 3'b001, 3'b100, 8'd5, 8'd3, 8'd5, 0, 0, 1, 1);
    endtask

    // Directed sequence
    initial begin
        RESET = 1'b0;
        CLR = 1'b0;
        CE = 4'b0000;
        SEL = 2'b00;
        S = 3'b000;
        W = 3'b000;
        A = 8'd0;
        B = 8'd0;

        #12;
        expectOut("reset_state", 8'd0, 0, 0, 0, 0);
        checkOutput();
        @(negedge CLK);
        RESET = 1'b1;

        // Default program, then FSM dwelling in its final state
        runDefault("prog");
        step("prog_y_hold1", 1'b0, 4'b0100, 2'b01, 3'b001, 3'b100, 8'd5, 8'd3, 8'd5, 0, 0, 1, 0);
        step("prog_y_hold2", 1'b0, 4'b0100, 2'b01, 3'b001, 3'b100, 8'd5, 8'd3, 8'd5, 0, 0, 1, 0);

        // Idle control words with wiggling inputs change nothing
        for (int i = 0; i < 10; i++) begin
            step("hold_idle", 1'b0, 4'b0000, i[1:0], i[2:0], i[2:0], 8'(i * 37 + 1), 8'(i * 11 + 200),
                 8'd5, 0, 0, 1, 0);
        end

        // Simultaneous R2/R3 load: R2 takes old R3 (5), R3 becomes 5+3
        step("simul_r2_old", 1'b0, 4'b1100, 2'b00, 3'b001, 3'b100, 8'd0, 8'd0, 8'd5, 0, 0, 1, 0);
        step("simul_r3_new", 1'b0, 4'b0100, 2'b00, 3'b000, 3'b100, 8'd0, 8'd0, 8'd8, 0, 0, 1, 0);

        // SEL=11: R3+R3 = 16
        step("sel11_add",    1'b0, 4'b1000, 2'b11, 3'b001, 3'b000, 8'd0, 8'd0, 8'd8, 0, 0, 1, 0);
        step("sel11_y",      1'b0, 4'b0100, 2'b00, 3'b000, 3'b100, 8'd0, 8'd0, 8'd16, 0, 0, 1, 0);

        // R2 source codes: unlisted, R0, R1, ALU (R3-R0 = 16-5)
        step("w_other",      1'b0, 4'b0100, 2'b00, 3'b000, 3'b011, 8'd0, 8'd0, 8'd0, 0, 0, 1, 0);
        step("w_r0",         1'b0, 4'b0100, 2'b00, 3'b000, 3'b000, 8'd0, 8'd0, 8'd5, 0, 0, 1, 0);
        step("w_r1",         1'b0, 4'b0100, 2'b00, 3'b000, 3'b001, 8'd0, 8'd0, 8'd3, 0, 0, 1, 0);
        step("w_alu_sub",    1'b0, 4'b0100, 2'b10, 3'b010, 3'b010, 8'd0, 8'd0, 8'd11, 0, 0, 1, 0);

        // Logic ops on A=0xA5, B=0x3C seen through W=ALU
        step("ops_load",     1'b0, 4'b0011, 2'b00, 3'b000, 3'b000, 8'hA5, 8'h3C, 8'd11, 0, 0, 1, 0);
        step("op_and",       1'b0, 4'b0100, 2'b00, 3'b011, 3'b010, 8'd0, 8'd0, 8'h24, 0, 0, 1, 0);
        step("op_or",        1'b0, 4'b0100, 2'b00, 3'b100, 3'b010, 8'd0, 8'd0, 8'hBD, 0, 0, 1, 0);
        step("op_xor",       1'b0, 4'b0100, 2'b00, 3'b101, 3'b010, 8'd0, 8'd0, 8'h99, 0, 0, 1, 0);
        step("op_shl",       1'b0, 4'b0100, 2'b00, 3'b110, 3'b010, 8'd0, 8'd0, 8'h4A, 0, 0, 1, 0);
        step("op_not",       1'b0, 4'b0100, 2'b00, 3'b111, 3'b010, 8'd0, 8'd0, 8'h5A, 0, 0, 1, 0);
        step("op_pass",      1'b0, 4'b0100, 2'b00, 3'b000, 3'b010, 8'd0, 8'd0, 8'hA5, 0, 0, 1, 0);

        // Shift carry out of the MSB, then AND to zero clears carry and sets ZERO
        step("shl_carry",    1'b0, 4'b1000, 2'b00, 3'b110, 3'b000, 8'd0, 8'd0, 8'hA5, 0, 1, 1, 0);
        step("and_zero",     1'b0, 4'b1000, 2'b10, 3'b011, 3'b000, 8'd0, 8'd0, 8'hA5, 1, 0, 1, 0);
        step("flags_hold",   1'b0, 4'b0100, 2'b00, 3'b000, 3'b100, 8'd0, 8'd0, 8'd0, 1, 0, 1, 0);

        // Add wrap / carry: 200+100
        step("wrap_clr",     1'b1, 4'b0000, 2'b00, 3'b000, 3'b000, 8'd0, 8'd0, 8'd0, 0, 0, 0, 0);
        step("wrap_load",    1'b0, 4'b0011, 2'b00, 3'b000, 3'b000, 8'd200, 8'd100, 8'd0, 0, 0, 0, 0);
        step("wrap_add",     1'b0, 4'b1000, 2'b00, 3'b001, 3'b000, 8'd0, 8'd0, 8'd0, 0, 1, 0, 0);
        step("wrap_y",       1'b0, 4'b0100, 2'b00, 3'b000, 3'b100, 8'd0, 8'd0, ADD_WRAP_RES, 0, 1, 1, 1);

        // Subtract borrow: 3-5
        step("borrow_clr",   1'b1, 4'b0000, 2'b00, 3'b000, 3'b000, 8'd0, 8'd0, 8'd0, 0, 0, 0, 0);
        step("borrow_load",  1'b0, 4'b0011, 2'b00, 3'b000, 3'b000, 8'd3, 8'd5, 8'd0, 0, 0, 0, 0);
        step("borrow_sub",   1'b0, 4'b1000, 2'b00, 3'b010, 3'b000, 8'd0, 8'd0, 8'd0, SUB_BORROW_ZERO, 1, 0, 0);
        step("borrow_y",     1'b0, 4'b0100, 2'b00, 3'b000, 3'b100, 8'd0, 8'd0, SUB_BORROW_RES, SUB_BORROW_ZERO, 1, 1, 1);

        // Equal operands: 7-7 = 0
        step("equal_load",   1'b0, 4'b0011, 2'b00, 3'b000, 3'b000, 8'd7, 8'd7, SUB_BORROW_RES, SUB_BORROW_ZERO, 1, 1, 0);
        step("equal_sub",    1'b0, 4'b1000, 2'b00, 3'b010, 3'b000, 8'd0, 8'd0, SUB_BORROW_RES, 1, 0, 1, 0);
        step("equal_y",      1'b0, 4'b0100, 2'b00, 3'b000, 3'b100, 8'd0, 8'd0, 8'd0, 1, 0, 1, 0);

        // CLR beats all load enables
        step("clr_prio",     1'b1, 4'b1111, 2'b00, 3'b001, 3'b000, 8'd9, 8'd9, 8'd0, 0, 0, 0, 0);
        step("clr_idle",     1'b0, 4'b0000, 2'b00, 3'b001, 3'b000, 8'd9, 8'd9, 8'd0, 0, 0, 0, 0);
        step("clr_r3_zero",  1'b0, 4'b0100, 2'b00, 3'b000, 3'b100, 8'd9, 8'd9, 8'd0, 0, 0, 1, 1);
        step("clr_r0_zero",  1'b0, 4'b0100, 2'b00, 3'b000, 3'b000, 8'd9, 8'd9, 8'd0, 0, 0, 1, 0);

        // Async reset between edges mid-program, then rerun
        runDefault("pre_reset");
        @(negedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        expectOut("async_reset", 8'd0, 0, 0, 0, 0);
        checkOutput();
        RESET = 1'b1;
        runDefault("rerun");

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
